db_bus_ctrl: RTL and testbench
==============================

DB_BUS_CTRL -- requirements
Module: db_bus_ctrl

Interface
REQ-001 SHALL have parameter RD_HOLD, default 2, meaning extra clk cycles db_oen stays high after the closing cck_edge.
REQ-002 SHALL have port clk, input, 1, 56 MHz system clock; all state on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports cck_edge and cckq_edge, input, 1 each, single-clk strobes marking any CCK and CCKQ transition.
REQ-005 SHALL have port cck, input, 1, resynchronised CCK level.
REQ-006 SHALL have port rga, input, 8 bits [8:1], register address bus.
REQ-007 SHALL have port db_in, input, 16, chip data bus.
REQ-008 SHALL have port rd_data, input, 16, read value from the core for reg_addr.
REQ-009 SHALL have ports reg_addr (output, 8, latched address), reg_wdata (output, 16, latched write data), reg_wr (output, 1, one-clk write strobe) and reg_rd (output, 1, one-clk read request).
REQ-010 SHALL have ports db_out (output, 16, drive value) and db_oen (output, 1, bus drive enable).

Function
REQ-011 SHALL implement states IDLE, ADDR, WRITE, READ, DRIVE and TURN.
REQ-012 IDLE: on a cckq_edge with cck=1, SHALL latch rga into reg_addr and go to ADDR.
REQ-013 ADDR: rga=8'hFF (NOP, byte 0x1FE) SHALL return to IDLE with no strobe.
REQ-014 ADDR: a readable address (DENISEID 0x07C, CLXDAT 0x00E, JOY0DAT 0x00A, JOY1DAT 0x00C) SHALL go to READ; any other address SHALL go to WRITE.
REQ-015 WRITE: on the next cck_edge with cck=0, SHALL latch db_in into reg_wdata, pulse reg_wr for exactly one clk and return to IDLE.
REQ-016 READ: SHALL pulse reg_rd for one clk; one clk later SHALL register rd_data into db_out, set db_oen=1 and enter DRIVE.
REQ-017 DRIVE: db_oen SHALL stay 1 until the next cck_edge with cck=0, then for RD_HOLD further clks, then go to TURN.
REQ-018 TURN: db_oen SHALL be 0 for exactly 1 clk, then IDLE; no new address SHALL be accepted during TURN.
REQ-019 If cck_edge and cckq_edge coincide, cck_edge SHALL take priority; the cckq_edge is dropped.
REQ-020 A cck_edge arriving in READ before db_oen rises SHALL abort the read: db_oen stays 0 and the state goes to IDLE.
REQ-021 The path from READ entry to db_oen=1 SHALL take exactly 2 clks.
REQ-022 reg_wr and reg_rd SHALL never be high in the same clk.
REQ-023 db_oen SHALL be glitch-free and registered, never decoded combinationally.

Reset
REQ-024 rst SHALL force IDLE, reg_addr=8'hFF, reg_wdata=0, db_out=0, and reg_wr, reg_rd and db_oen to 0, without waiting for clk.
REQ-025 rst asserted in DRIVE SHALL drop db_oen in the same instant; after rst deasserts, operation SHALL resume at the next qualifying cckq_edge.

Configuration
REQ-026 Macro DB_READ_EN: when defined, reads SHALL operate as in REQ-014 to REQ-018.
REQ-027 Without DB_READ_EN: READ, DRIVE and TURN SHALL be omitted; readable addresses SHALL return to IDLE with no strobe; db_oen SHALL be constant 0 and db_out constant 0.

Structure
REQ-028 Package denise_pkg SHALL hold the state enum, the readable-address constants, and the NOP constant 8'hFF.
REQ-029 Sub-module db_rga_decode SHALL provide combinational classification of an address as NOP, readable or writable.

Verification
REQ-030 Write: rga=8'h90 (0x120) with db_in=16'h1234 at a cckq_edge, then cck fall -> one reg_wr pulse, reg_addr=8'h90, reg_wdata=16'h1234.
REQ-031 Read: rga=8'h3E (DENISEID) with rd_data=16'h00FC -> reg_rd pulse; 2 clks later db_oen=1 and db_out=16'h00FC; db_oen low 2 clks after the cck fall, then a 1-clk TURN.
REQ-032 NOP: rga=8'hFF over 10 CCK cycles -> no reg_wr, no reg_rd, db_oen=0 throughout.
REQ-033 Coincidence: cck_edge and cckq_edge in the same clk -> no address latched in that clk.
REQ-034 Reset in DRIVE: rst asserted -> db_oen=0 immediately, all outputs at reset values; the next read completes normally.
REQ-035 Build without DB_READ_EN: rga=8'h07 (CLXDAT) -> db_oen stays 0 and no strobes are issued.

Source files
------------

// File: rtl/denise_pkg.sv
// Shared types and register-address constants for the Denise chip-bus controller.
// Addresses are rga[8:1], i.e. the byte address shifted right by one.
package denise_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_WRITE = 3'd2,
      ST_READ  = 3'd3,
      ST_DRIVE = 3'd4,
      ST_TURN  = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      CLS_NOP   = 2'd0,
      CLS_READ  = 2'd1,
      CLS_WRITE = 2'd2
   } rga_class_t;

   localparam logic [7:0] RGA_NOP      = 8'hFF;  // byte 0x1FE
   localparam logic [7:0] RGA_DENISEID = 8'h3E;  // byte 0x07C
   localparam logic [7:0] RGA_CLXDAT   = 8'h07;  // byte 0x00E
   localparam logic [7:0] RGA_JOY0DAT  = 8'h05;  // byte 0x00A
   localparam logic [7:0] RGA_JOY1DAT  = 8'h06;  // byte 0x00C

endpackage

// File: rtl/db_rga_decode.sv
// Combinational classification of a latched register address as NOP, readable
// or writable.
module db_rga_decode
   import denise_pkg::*;
(
   input  logic [7:0]  addr,
   output rga_class_t  cls
);

   always_comb begin
      cls = CLS_WRITE;
      case (addr)
         RGA_NOP:      cls = CLS_NOP;
         RGA_DENISEID,
         RGA_CLXDAT,
         RGA_JOY0DAT,
         RGA_JOY1DAT:  cls = CLS_READ;
         default:      cls = CLS_WRITE;
      endcase
   end

endmodule

// File: rtl/db_bus_ctrl.sv
// Chip-bus slave for Denise: latches rga on CCKQ, writes on the CCK fall and,
// when DB_READ_EN is defined, drives read data onto the bus with a turnaround.
module db_bus_ctrl
   import denise_pkg::*;
#(
   parameter int unsigned RD_HOLD = 2
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        cck_edge,
   input  logic        cckq_edge,
   input  logic        cck,
   input  logic [8:1]  rga,
   input  logic [15:0] db_in,
   input  logic [15:0] rd_data,
   output logic [7:0]  reg_addr,
   output logic [15:0] reg_wdata,
   output logic        reg_wr,
   output logic        reg_rd,
   output logic [15:0] db_out,
   output logic        db_oen,
   output state_t      dbg_state
);

   localparam int CNT_W = (RD_HOLD < 2) ? 1 : $clog2(RD_HOLD + 1);

   state_t      state, state_n;
   rga_class_t  addr_cls;
   logic [7:0]  addr_n;
   logic [15:0] wdata_n;
   logic        wr_n;
   logic        cck_fall;
   logic        addr_take;

`ifdef DB_READ_EN
   logic             rd_q, rd_n;
   logic             oen_q, oen_n;
   logic             ph_q, ph_n;
   logic [15:0]      dout_q, dout_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
`endif

   // cck_edge wins over a coincident cckq_edge, so the address is only
   // taken when no CCK transition is flagged in the same clk.
   assign cck_fall  = cck_edge & ~cck;
   assign addr_take = cckq_edge & ~cck_edge & cck;
   assign dbg_state = state;

   db_rga_decode u_decode (
      .addr (reg_addr),
      .cls  (addr_cls)
   );

   always_comb begin
      state_n = state;
      addr_n  = reg_addr;
      wdata_n = reg_wdata;
      wr_n    = 1'b0;
`ifdef DB_READ_EN
      rd_n    = 1'b0;
      oen_n   = oen_q;
      ph_n    = ph_q;
      dout_n  = dout_q;
      cnt_n   = cnt_q;
`endif
      case (state)
         ST_IDLE: begin
            if (addr_take) begin
               addr_n  = rga;
               state_n = ST_ADDR;
            end
         end
         ST_ADDR: begin
            case (addr_cls)
               CLS_WRITE: state_n = ST_WRITE;
`ifdef DB_READ_EN
               CLS_READ: begin
                  rd_n    = 1'b1;
                  ph_n    = 1'b0;
                  state_n = ST_READ;
               end
`endif
               default:   state_n = ST_IDLE;
            endcase
         end
         ST_WRITE: begin
            if (cck_fall) begin
               wdata_n = db_in;
               wr_n    = 1'b1;
               state_n = ST_IDLE;
            end
         end
`ifdef DB_READ_EN
         // Two clks in READ: request strobe, then capture core data.
         ST_READ: begin
            if (cck_edge) begin
               ph_n    = 1'b0;
               state_n = ST_IDLE;
            end else if (ph_q) begin
               dout_n  = rd_data;
               oen_n   = 1'b1;
               ph_n    = 1'b0;
               state_n = ST_DRIVE;
            end else begin
               ph_n = 1'b1;
            end
         end
         ST_DRIVE: begin
            if (cnt_q != '0) begin
               if (cnt_q == CNT_W'(1)) begin
                  oen_n   = 1'b0;
                  cnt_n   = '0;
                  state_n = ST_TURN;
               end else begin
                  cnt_n = cnt_q - CNT_W'(1);
               end
            end else if (cck_fall) begin
               if (RD_HOLD == 0) begin
                  oen_n   = 1'b0;
                  state_n = ST_TURN;
               end else begin
                  cnt_n = CNT_W'(RD_HOLD);
               end
            end
         end
         ST_TURN: state_n = ST_IDLE;
`endif
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         reg_addr  <= RGA_NOP;
         reg_wdata <= '0;
         reg_wr    <= 1'b0;
      end else begin
         state     <= state_n;
         reg_addr  <= addr_n;
         reg_wdata <= wdata_n;
         reg_wr    <= wr_n;
      end
   end

`ifdef DB_READ_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q   <= 1'b0;
         oen_q  <= 1'b0;
         ph_q   <= 1'b0;
         dout_q <= '0;
         cnt_q  <= '0;
      end else begin
         rd_q   <= rd_n;
         oen_q  <= oen_n;
         ph_q   <= ph_n;
         dout_q <= dout_n;
         cnt_q  <= cnt_n;
      end
   end

   assign reg_rd = rd_q;
   assign db_oen = oen_q;
   assign db_out = dout_q;
`else
   logic             unused_rd;
   logic [CNT_W-1:0] unused_hold;

   assign unused_rd   = ^rd_data;
   assign unused_hold = CNT_W'(RD_HOLD);
   assign reg_rd      = 1'b0;
   assign db_oen      = 1'b0;
   assign db_out      = '0;
`endif

endmodule

// File: tb/tb_db_bus_ctrl.sv
// Directed self-checking bench for db_bus_ctrl; read scenarios are built only
// when DB_READ_EN is defined, otherwise the read-disabled behaviour is checked.
module tb_db_bus_ctrl;
   import denise_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cck_edge = 1'b0;
   logic        cckq_edge = 1'b0;
   logic        cck = 1'b0;
   logic [8:1]  rga = 8'hFF;
   logic [15:0] db_in = '0;
   logic [15:0] rd_data = '0;
   logic [7:0]  reg_addr;
   logic [15:0] reg_wdata;
   logic        reg_wr;
   logic        reg_rd;
   logic [15:0] db_out;
   logic        db_oen;
   state_t      dbg_state;

   int checks = 0;
   int errors = 0;
   int wr_seen = 0;
   int rd_seen = 0;
   int oen_seen = 0;
   int both_seen = 0;
   int wr0, rd0, oen0;

   db_bus_ctrl #(.RD_HOLD(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .cck_edge  (cck_edge),
      .cckq_edge (cckq_edge),
      .cck       (cck),
      .rga       (rga),
      .db_in     (db_in),
      .rd_data   (rd_data),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_wr    (reg_wr),
      .reg_rd    (reg_rd),
      .db_out    (db_out),
      .db_oen    (db_oen),
      .dbg_state (dbg_state)
   );

   // clock / reset
   always #9 clk = ~clk;

   always @(negedge clk) begin
      if (reg_wr) wr_seen++;
      if (reg_rd) rd_seen++;
      if (db_oen) oen_seen++;
      if (reg_wr && reg_rd) both_seen++;
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cck_rise();
      cck = 1'b1;
      cck_edge = 1'b1;
      tick();
      cck_edge = 1'b0;
   endtask

   task automatic cck_down();
      cck = 1'b0;
      cck_edge = 1'b1;
      tick();
      cck_edge = 1'b0;
   endtask

   task automatic cckq();
      cckq_edge = 1'b1;
      tick();
      cckq_edge = 1'b0;
   endtask

   task automatic snap();
      wr0 = wr_seen;
      rd0 = rd_seen;
      oen0 = oen_seen;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
      checks++; if (reg_addr !== 8'hFF) begin errors++; $display("FAIL reset_addr: got %h expected ff", reg_addr); end
      checks++; if (reg_wdata !== 16'h0000) begin errors++; $display("FAIL reset_wdata: got %h expected 0000", reg_wdata); end
      checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b expected 0", reg_wr); end
      checks++; if (reg_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b expected 0", reg_rd); end
      checks++; if (db_oen !== 1'b0) begin errors++; $display("FAIL reset_oen: got %b expected 0", db_oen); end
      checks++; if (db_out !== 16'h0000) begin errors++; $display("FAIL reset_dout: got %h expected 0000", db_out); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_write();
      snap();
      cck_rise();
      rga = 8'h90;
      db_in = 16'h1234;
      cckq();
      checks++; if (reg_addr !== 8'h90) begin errors++; $display("FAIL wr_addr: got %h expected 90", reg_addr); end
      checks++; if (dbg_state !== ST_ADDR) begin errors++; $display("FAIL wr_addr_state: got %0d expected %0d", dbg_state, ST_ADDR); end
      tick();
      checks++; if (dbg_state !== ST_WRITE) begin errors++; $display("FAIL wr_state: got %0d expected %0d", dbg_state, ST_WRITE); end
      cck_down();
      checks++; if (reg_wr !== 1'b1) begin errors++; $display("FAIL wr_strobe: got %b expected 1", reg_wr); end
      checks++; if (reg_wdata !== 16'h1234) begin errors++; $display("FAIL wr_data: got %h expected 1234", reg_wdata); end
      db_in = 16'hDEAD;
      repeat (3) tick();
      checks++; if (wr_seen - wr0 !== 1) begin errors++; $display("FAIL wr_pulse_count: got %0d expected 1", wr_seen - wr0); end
      checks++; if (reg_wdata !== 16'h1234) begin errors++; $display("FAIL wr_data_hold: got %h expected 1234", reg_wdata); end
      checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL wr_end_state: got %0d expected %0d", dbg_state, ST_IDLE); end
   endtask

   task automatic test_nop();
      snap();
      rga = 8'hFF;
      for (int i = 0; i < 10; i++) begin
         cck_rise();
         cckq();
         tick();
         cck_down();
         cckq();
         tick();
      end
      checks++; if (wr_seen - wr0 !== 0) begin errors++; $display("FAIL nop_wr: got %0d expected 0", wr_seen - wr0); end
      checks++; if (rd_seen - rd0 !== 0) begin errors++; $display("FAIL nop_rd: got %0d expected 0", rd_seen - rd0); end
      checks++; if (oen_seen - oen0 !== 0) begin errors++; $display("FAIL nop_oen: got %0d expected 0", oen_seen - oen0); end
      checks++; if (reg_addr !== 8'hFF) begin errors++; $display("FAIL nop_addr: got %h expected ff", reg_addr); end
   endtask

   task automatic test_coincide();
      rga = 8'h90;
      cck = 1'b1;
      cck_edge = 1'b1;
      cckq_edge = 1'b1;
      tick();
      cck_edge = 1'b0;
      cckq_edge = 1'b0;
      checks++; if (reg_addr !== 8'hFF) begin errors++; $display("FAIL coincide_addr: got %h expected ff", reg_addr); end
      checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL coincide_state: got %0d expected %0d", dbg_state, ST_IDLE); end
      tick();
      checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL coincide_state2: got %0d expected %0d", dbg_state, ST_IDLE); end
      cck_down();
   endtask

`ifdef DB_READ_EN
   task automatic test_read();
      cck_rise();
      rga = 8'h3E;
      rd_data = 16'h00FC;
      cckq();
      tick();
      checks++; if (reg_rd !== 1'b1) begin errors++; $display("FAIL rd_strobe: got %b expected 1", reg_rd); end
      checks++; if (db_oen !== 1'b0) begin errors++; $display("FAIL rd_oen_early0: got %b expected 0", db_oen); end
      tick();
      checks++; if (reg_rd !== 1'b0) begin errors++; $display("FAIL rd_strobe_end: got %b expected 0", reg_rd); end
      checks++; if (db_oen !== 1'b0) begin errors++; $display("FAIL rd_oen_early1: got %b expected 0", db_oen); end
      tick();
      checks++; if (db_oen !== 1'b1) begin errors++; $display("FAIL rd_oen_rise: got %b expected 1", db_oen); end
      checks++; if (db_out !== 16'h00FC) begin errors++; $display("FAIL rd_dout: got %h expected 00fc", db_out); end
      checks++; if (dbg_state !== ST_DRIVE) begin errors++; $display("FAIL rd_drive_state: got %0d expected %0d", dbg_state, ST_DRIVE); end
      rd_data = 16'h5555;
      repeat (3) tick();
      checks++; if (db_oen !== 1'b1 || db_out !== 16'h00FC) begin errors++; $display("FAIL rd_drive_hold: got %b/%h expected 1/00fc", db_oen, db_out); end
      cck_down();
      checks++; if (db_oen !== 1'b1) begin errors++; $display("FAIL rd_hold0: got %b expected 1", db_oen); end
      tick();
      checks++; if (db_oen !== 1'b1) begin errors++; $display("FAIL rd_hold1: got %b expected 1", db_oen); end
      tick();
      checks++; if (db_oen !== 1'b0) begin errors++; $display("FAIL rd_oen_fall: got %b expected 0", db_oen); end
      checks++; if (dbg_state !== ST_TURN) begin errors++; $display("FAIL rd_turn: got %0d expected %0d", dbg_state, ST_TURN); end
      // Qualifying address strobe during TURN must be ignored.
      rga = 8'h90;
      cck = 1'b1;
      cckq_edge = 1'b1;
      tick();
      cckq_edge = 1'b0;
      checks++; if (dbg_state !== ST_IDLE || reg_addr !== 8'h3E) begin errors++; $display("FAIL rd_turn_block: got %0d/%h expected %0d/3e", dbg_state, reg_addr, ST_IDLE); end
      checks++; if (db_oen !== 1'b0) begin errors++; $display("FAIL rd_after_turn_oen: got %b expected 0", db_oen); end
      cck_down();
   endtask

   task automatic test_read_abort();
      snap();
      cck_rise();
      rga = 8'h07;
      rd_data = 16'hAAAA;
      cckq();
      tick();
      checks++; if (dbg_state !== ST_READ || reg_rd !== 1'b1) begin errors++; $display("FAIL abort_enter: got %0d/%b expected %0d/1", dbg_state, reg_rd, ST_READ); end
      cck_down();
      checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL abort_state: got %0d expected %0d", dbg_state, ST_IDLE); end
      repeat (3) tick();
      checks++; if (oen_seen - oen0 !== 0) begin errors++; $display("FAIL abort_oen: got %0d expected 0", oen_seen - oen0); end
      checks++; if (db_out !== 16'h00FC) begin errors++; $display("FAIL abort_dout: got %h expected 00fc", db_out); end
   endtask

   task automatic test_reset_in_drive();
      cck_rise();
      rga = 8'h05;
      rd_data = 16'h1357;
      cckq();
      repeat (3) tick();
      checks++; if (db_oen !== 1'b1 || db_out !== 16'h1357) begin errors++; $display("FAIL rst_pre_drive: got %b/%h expected 1/1357", db_oen, db_out); end
      #2 rst = 1'b1;
      #1;
      checks++; if (db_oen !== 1'b0) begin errors++; $display("FAIL rst_oen_async: got %b expected 0", db_oen); end
      checks++; if (db_out !== 16'h0000 || reg_addr !== 8'hFF) begin errors++; $display("FAIL rst_vals: got %h/%h expected 0000/ff", db_out, reg_addr); end
      checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d expected %0d", dbg_state, ST_IDLE); end
      tick();
      rst = 1'b0;
      tick();
      cck_down();
      cck_rise();
      rga = 8'h3E;
      rd_data = 16'hBEEF;
      cckq();
      repeat (3) tick();
      checks++; if (db_oen !== 1'b1 || db_out !== 16'hBEEF) begin errors++; $display("FAIL rst_next_read: got %b/%h expected 1/beef", db_oen, db_out); end
      cck_down();
      repeat (2) tick();
      checks++; if (db_oen !== 1'b0 || dbg_state !== ST_TURN) begin errors++; $display("FAIL rst_next_turn: got %b/%0d expected 0/%0d", db_oen, dbg_state, ST_TURN); end
      tick();
      checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_next_idle: got %0d expected %0d", dbg_state, ST_IDLE); end
   endtask
`else
   task automatic test_no_read();
      snap();
      cck_rise();
      rga = 8'h07;
      rd_data = 16'hFFFF;
      cckq();
      checks++; if (dbg_state !== ST_ADDR) begin errors++; $display("FAIL noread_addr: got %0d expected %0d", dbg_state, ST_ADDR); end
      tick();
      checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL noread_idle: got %0d expected %0d", dbg_state, ST_IDLE); end
      cck_down();
      repeat (4) tick();
      checks++; if (wr_seen - wr0 !== 0 || rd_seen - rd0 !== 0) begin errors++; $display("FAIL noread_strobes: got %0d/%0d expected 0/0", wr_seen - wr0, rd_seen - rd0); end
      checks++; if (oen_seen - oen0 !== 0) begin errors++; $display("FAIL noread_oen: got %0d expected 0", oen_seen - oen0); end
      checks++; if (db_out !== 16'h0000) begin errors++; $display("FAIL noread_dout: got %h expected 0000", db_out); end
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_nop();
      test_coincide();
`ifdef DB_READ_EN
      test_read();
      test_read_abort();
      test_reset_in_drive();
`else
      test_no_read();
`endif
      checks++; if (both_seen !== 0) begin errors++; $display("FAIL wr_rd_overlap: got %0d expected 0", both_seen); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
